// File: rtl/saph_fpu_arbiter_pkg.sv
// saph_fpu_arbiter_pkg: shared SAPH FPU definitions.
//   - data/mode widths of the saph_fpi FPU interface
//   - FPU operation encodings (carried through d_mode, never decoded here)
//   - arbiter state enum, tag pipeline entry, perf counter width
//   - saph_fpu_oh2idx: one-hot (up to 8 bits) to index helper
package saph_fpu_arbiter_pkg;

  localparam int unsigned SAPH_FPU_DATA_W = 32;
  localparam int unsigned SAPH_FPU_MODE_W = 2;
  localparam int unsigned SAPH_FPU_IDX_W  = 3;   // enough for 8 requesters
  localparam int unsigned SAPH_FPU_PERF_W = 32;

  typedef enum logic [SAPH_FPU_MODE_W-1:0] {
    SAPH_FPU_FADD = 2'd0,
    SAPH_FPU_FSUB = 2'd1,
    SAPH_FPU_FMUL = 2'd2,
    SAPH_FPU_FDIV = 2'd3
  } saph_fpu_mode_e;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } saph_fpu_arb_state_e;

  typedef struct packed {
    logic                      vld;
    logic [SAPH_FPU_IDX_W-1:0] idx;
  } saph_fpu_tag_t;

  function automatic logic [SAPH_FPU_IDX_W-1:0] saph_fpu_oh2idx(input logic [7:0] oh);
    logic [SAPH_FPU_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/saph_fpi.sv
// saph_fpi: SAPH FPU request/result interface.
//   d_trig/d_lhs/d_rhs/d_mode : operation request (client -> FPU)
//   d_ready                   : FPU accepts the request this cycle
//   q_res                     : result, valid 'latency' cycles after acceptance
// Modports: FPU (the unit side), GPU (the client side).
interface saph_fpi #(
  parameter int unsigned latency = 2
) ();
  import saph_fpu_arbiter_pkg::*;

  logic                       d_trig;
  logic [SAPH_FPU_DATA_W-1:0] d_lhs;
  logic [SAPH_FPU_DATA_W-1:0] d_rhs;
  logic [SAPH_FPU_MODE_W-1:0] d_mode;
  logic                       d_ready;
  logic [SAPH_FPU_DATA_W-1:0] q_res;

  modport FPU (input d_trig, d_lhs, d_rhs, d_mode, output d_ready, q_res);
  modport GPU (output d_trig, d_lhs, d_rhs, d_mode, input d_ready, q_res);
endinterface

// File: rtl/saph_fpu_arbiter_rr_pick.sv
// saph_rr_pick: rotating-priority picker.
//   req   : request vector
//   ptr   : index with highest priority; priority falls off upward modulo N
//   grant : one-hot winner, 0 when req is 0
module saph_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/saph_fpu_arbiter.sv
// saph_fpu_arbiter: shares one FPU between 'ports' requesters.
//   clk, rst  : clock, asynchronous active-high reset
//   req[]     : requester-facing saph_fpi (FPU modport)
//   fpu       : the shared FPU (GPU modport)
//   grant     : one-hot requester currently driving fpu, 0 when none
//   q_valid   : one-cycle strobe, marked requester's result is on q_res
// Optional (SAPH_FPU_ARB_PERF_EN): perf_clr, perf_grants[] (per-port
// acceptances), perf_stalls (cycles with a request but no acceptance);
// all saturating.
// Request path is purely combinational; a stalled grant is held until it is
// accepted or its requester withdraws.
module saph_fpu_arbiter
  import saph_fpu_arbiter_pkg::*;
#(
  parameter int unsigned ports   = 2,
  parameter int unsigned latency = 2
) (
  input  logic             clk,
  input  logic             rst,
  saph_fpi.FPU             req [ports],
  saph_fpi.GPU             fpu,
  output logic [ports-1:0] grant,
  output logic [ports-1:0] q_valid
`ifdef SAPH_FPU_ARB_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [SAPH_FPU_PERF_W-1:0] perf_grants [ports],
  output logic [SAPH_FPU_PERF_W-1:0] perf_stalls
`endif
);

  localparam int unsigned IW = $clog2(ports);

  if (ports < 2 || ports > 8) begin : g_bad_ports
    $error("saph_fpu_arbiter: ports must be 2..8");
  end
  if (latency < 1) begin : g_bad_latency
    $error("saph_fpu_arbiter: latency must be at least 1");
  end
  if (fpu.latency != latency) begin : g_bad_fpu_lat
    $error("saph_fpu_arbiter: fpu.latency differs from latency");
  end

  logic [ports-1:0]           trig;
  logic [SAPH_FPU_DATA_W-1:0] lhs  [ports];
  logic [SAPH_FPU_DATA_W-1:0] rhs  [ports];
  logic [SAPH_FPU_MODE_W-1:0] mode [ports];

  for (genvar i = 0; i < ports; i++) begin : g_req
    if (req[i].latency != latency) begin : g_bad_req_lat
      $error("saph_fpu_arbiter: req latency differs from latency");
    end
    assign trig[i]        = req[i].d_trig;
    assign lhs[i]         = req[i].d_lhs;
    assign rhs[i]         = req[i].d_rhs;
    assign mode[i]        = req[i].d_mode;
    assign req[i].d_ready = grant[i] & fpu.d_ready;
    assign req[i].q_res   = fpu.q_res;
  end

  saph_fpu_arb_state_e state;
  logic [IW-1:0]       rr_ptr;
  logic [ports-1:0]    hold_grant;
  logic [ports-1:0]    pick;
  logic                accept;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       ptr_next;
  saph_fpu_tag_t       tag [latency];

  saph_rr_pick #(.N(ports), .IW(IW)) u_pick (
    .req   (trig),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  // In HOLD the grant is masked by the held requester's own trigger so a
  // withdrawn request immediately stops driving fpu.d_trig.
  always_comb begin
    if (rst)                grant = '0;
    else if (state == HOLD) grant = hold_grant & trig;
    else                    grant = pick;
  end

  assign accept   = (|grant) & fpu.d_ready;
  assign gidx     = IW'(saph_fpu_oh2idx(8'(grant)));
  assign ptr_next = (gidx == IW'(ports - 1)) ? '0 : gidx + IW'(1);

  logic [SAPH_FPU_DATA_W-1:0] mux_lhs, mux_rhs;
  logic [SAPH_FPU_MODE_W-1:0] mux_mode;

  always_comb begin
    mux_lhs  = '0;
    mux_rhs  = '0;
    mux_mode = '0;
    for (int unsigned i = 0; i < ports; i++) begin
      if (grant[i]) begin
        mux_lhs  = lhs[i];
        mux_rhs  = rhs[i];
        mux_mode = mode[i];
      end
    end
  end

  assign fpu.d_trig = |grant;
  assign fpu.d_lhs  = mux_lhs;
  assign fpu.d_rhs  = mux_rhs;
  assign fpu.d_mode = mux_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      hold_grant <= '0;
    end else begin
      case (state)
        ARB: begin
          if (|grant) begin
            if (fpu.d_ready) begin
              rr_ptr <= ptr_next;
            end else begin
              state      <= HOLD;
              hold_grant <= grant;
            end
          end
        end
        HOLD: begin
          if (!(|grant)) begin
            state <= ARB;
          end else if (fpu.d_ready) begin
            rr_ptr <= ptr_next;
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < latency; k++) tag[k] <= '0;
    end else begin
      tag[0].vld <= accept;
      tag[0].idx <= saph_fpu_oh2idx(8'(grant));
      for (int unsigned k = 1; k < latency; k++) tag[k] <= tag[k-1];
    end
  end

  always_comb begin
    q_valid = '0;
    for (int unsigned i = 0; i < ports; i++) begin
      q_valid[i] = tag[latency-1].vld && (tag[latency-1].idx == 3'(i));
    end
  end

`ifdef SAPH_FPU_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ports; i++) perf_grants[i] <= '0;
      perf_stalls <= '0;
    end else if (perf_clr) begin
      for (int unsigned i = 0; i < ports; i++) perf_grants[i] <= '0;
      perf_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < ports; i++) begin
        if (grant[i] && fpu.d_ready && perf_grants[i] != '1)
          perf_grants[i] <= perf_grants[i] + 1'b1;
      end
      if ((|trig) && !accept && perf_stalls != '1)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Directed bench for saph_fpu_arbiter: a 2-port/latency-2 instance driven
// from a per-cycle vector table, plus hand-written sequences for reset
// mid-operation, 4-port rotation (latency 3) and the optional perf counters.
module tb_saph_fpu_arbiter;
  import saph_fpu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- 2-port instance, latency 2 ----------------
  logic [1:0]  trig2;
  logic        rdy2;
  logic [31:0] qres_in2;
  logic [1:0]  grant2, qv2, dr2;
  logic [31:0] qres_out2 [2];

  saph_fpi #(.latency(2)) rq2 [2] ();
  saph_fpi #(.latency(2)) f2 ();

  for (genvar i = 0; i < 2; i++) begin : g_r2
    assign rq2[i].d_trig = trig2[i];
    assign rq2[i].d_lhs  = 32'h1000_0000 + 32'(i);
    assign rq2[i].d_rhs  = 32'h2000_0000 + 32'(i);
    assign rq2[i].d_mode = (i == 0) ? 2'(SAPH_FPU_FADD) : 2'(SAPH_FPU_FMUL);
    assign dr2[i]        = rq2[i].d_ready;
    assign qres_out2[i]  = rq2[i].q_res;
  end
  assign f2.d_ready = rdy2;
  assign f2.q_res   = qres_in2;

  // ---------------- 4-port instance, latency 3 ----------------
  logic [3:0]  trig4;
  logic        rdy4;
  logic [3:0]  grant4, qv4;

  saph_fpi #(.latency(3)) rq4 [4] ();
  saph_fpi #(.latency(3)) f4 ();

  for (genvar i = 0; i < 4; i++) begin : g_r4
    assign rq4[i].d_trig = trig4[i];
    assign rq4[i].d_lhs  = 32'h4000_0000 + 32'(i);
    assign rq4[i].d_rhs  = 32'h5000_0000 + 32'(i);
    assign rq4[i].d_mode = 2'(SAPH_FPU_FSUB);
  end
  assign f4.d_ready = rdy4;
  assign f4.q_res   = 32'hFACE_0004;

`ifdef SAPH_FPU_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] pg2 [2];
  logic [31:0] ps2;
  logic [31:0] pg4 [4];
  logic [31:0] ps4;
`endif

  saph_fpu_arbiter #(.ports(2), .latency(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .req     (rq2),
    .fpu     (f2),
    .grant   (grant2),
    .q_valid (qv2)
`ifdef SAPH_FPU_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grants (pg2),
    .perf_stalls (ps2)
`endif
  );

  saph_fpu_arbiter #(.ports(4), .latency(3)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .req     (rq4),
    .fpu     (f4),
    .grant   (grant4),
    .q_valid (qv4)
`ifdef SAPH_FPU_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grants (pg4),
    .perf_stalls (ps4)
`endif
  );

  function automatic logic [31:0] exp_lhs2(input logic [1:0] g);
    case (g)
      2'b01:   return 32'h1000_0000;
      2'b10:   return 32'h1000_0001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] exp_mode2(input logic [1:0] g);
    case (g)
      2'b01:   return 2'(SAPH_FPU_FADD);
      2'b10:   return 2'(SAPH_FPU_FMUL);
      default: return 2'b00;
    endcase
  endfunction

  typedef struct {
    logic [1:0] trig;
    logic       rdy;
    logic [1:0] g;
    logic [1:0] qv;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // trig, ready -> expected grant, q_valid (2 ports, latency 2)
    tbl[0]  = '{2'b11, 1'b1, 2'b01, 2'b00}; // both trig: port 0 first
    tbl[1]  = '{2'b10, 1'b1, 2'b10, 2'b00}; // then port 1
    tbl[2]  = '{2'b00, 1'b1, 2'b00, 2'b01}; // result for row 0
    tbl[3]  = '{2'b00, 1'b1, 2'b00, 2'b10}; // result for row 1
    tbl[4]  = '{2'b10, 1'b0, 2'b10, 2'b00}; // port 1 stalls -> HOLD
    tbl[5]  = '{2'b11, 1'b0, 2'b10, 2'b00}; // held despite port 0
    tbl[6]  = '{2'b11, 1'b0, 2'b10, 2'b00};
    tbl[7]  = '{2'b11, 1'b1, 2'b10, 2'b00}; // accepted on 4th cycle
    tbl[8]  = '{2'b01, 1'b1, 2'b01, 2'b00};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 2'b10};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 2'b01};
    tbl[11] = '{2'b10, 1'b0, 2'b10, 2'b00}; // rr_ptr=1, port 1 held
    tbl[12] = '{2'b01, 1'b0, 2'b00, 2'b00}; // held port drops trig
    tbl[13] = '{2'b11, 1'b1, 2'b10, 2'b00}; // rr_ptr still 1
    tbl[14] = '{2'b01, 1'b1, 2'b01, 2'b00};
    tbl[15] = '{2'b00, 1'b1, 2'b00, 2'b10};
    tbl[16] = '{2'b00, 1'b1, 2'b00, 2'b01};
    tbl[17] = '{2'b00, 1'b1, 2'b00, 2'b00};

    rst = 1'b1;
    trig2 = 2'b11; rdy2 = 1'b1; qres_in2 = '0;
    trig4 = 4'hF;  rdy4 = 1'b1;
`ifdef SAPH_FPU_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // reset state, with requests present
    #2;
    chk("rst_grant2", 64'(grant2), 64'h0);
    chk("rst_qv2", 64'(qv2), 64'h0);
    chk("rst_fpu_trig2", 64'(f2.d_trig), 64'h0);
    chk("rst_grant4", 64'(grant4), 64'h0);
    chk("rst_qv4", 64'(qv4), 64'h0);

    @(posedge clk); #1;
    rst = 1'b0; trig2 = '0; trig4 = '0;

    // table-driven 2-port run
    for (int r = 0; r < 18; r++) begin
      @(posedge clk); #1;
      trig2 = tbl[r].trig;
      rdy2 = tbl[r].rdy;
      qres_in2 = 32'hC0DE_0000 + 32'(r);
      @(negedge clk);
      chk($sformatf("row%0d_grant", r), 64'(grant2), 64'(tbl[r].g));
      chk($sformatf("row%0d_qvalid", r), 64'(qv2), 64'(tbl[r].qv));
      chk($sformatf("row%0d_fpu_trig", r), 64'(f2.d_trig), 64'(|tbl[r].g));
      chk($sformatf("row%0d_dready", r), 64'(dr2), 64'(tbl[r].g & {2{tbl[r].rdy}}));
      chk($sformatf("row%0d_lhs", r), 64'(f2.d_lhs), 64'(exp_lhs2(tbl[r].g)));
      chk($sformatf("row%0d_mode", r), 64'(f2.d_mode), 64'(exp_mode2(tbl[r].g)));
      chk($sformatf("row%0d_qres", r), {qres_out2[1], qres_out2[0]},
          {2{32'hC0DE_0000 + 32'(r)}});
    end

    // reset one cycle after an acceptance (rr_ptr is 1 here)
    @(posedge clk); #1;
    trig2 = 2'b01; rdy2 = 1'b1;
    @(negedge clk);
    chk("rs_accept_grant", 64'(grant2), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1; trig2 = 2'b11;
    @(negedge clk);
    chk("rs_in_rst_grant", 64'(grant2), 64'h0);
    chk("rs_in_rst_fpu_trig", 64'(f2.d_trig), 64'h0);
    chk("rs_in_rst_qv", 64'(qv2), 64'h0);
    chk("rs_in_rst_dready", 64'(dr2), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; trig2 = 2'b00;
    @(negedge clk);
    chk("rs_dropped_qv", 64'(qv2), 64'h0);
    @(posedge clk); #1;
    trig2 = 2'b11;
    @(negedge clk);
    chk("rs_after_grant_p0", 64'(grant2), 64'h1);
    @(posedge clk); #1;
    trig2 = 2'b00;
    @(negedge clk);
    chk("rs_after_qv_early", 64'(qv2), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_after_qv", 64'(qv2), 64'h1);

    // 4 ports all requesting for 8 cycles, latency 3
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      trig4 = (k < 8) ? 4'hF : 4'h0;
      rdy4 = 1'b1;
      @(negedge clk);
      chk($sformatf("rot%0d_grant", k), 64'(grant4), (k < 8) ? 64'(1) << (k % 4) : 64'h0);
      chk($sformatf("rot%0d_qvalid", k), 64'(qv4),
          (k >= 3 && k < 11) ? 64'(1) << ((k - 3) % 4) : 64'h0);
      chk($sformatf("rot%0d_lhs", k), 64'(f4.d_lhs),
          (k < 8) ? 64'h4000_0000 + 64'(k % 4) : 64'h0);
    end

`ifdef SAPH_FPU_ARB_PERF_EN
    @(posedge clk); #1;
    perf_clr = 1'b1; trig2 = 2'b00; rdy2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      perf_clr = 1'b0;
      trig2 = 2'b01;
      rdy2 = (k < 5);
    end
    @(posedge clk); #1;
    trig2 = 2'b00; rdy2 = 1'b1;
    @(negedge clk);
    chk("perf_grants0", 64'(pg2[0]), 64'd5);
    chk("perf_grants1", 64'(pg2[1]), 64'd0);
    chk("perf_stalls", 64'(ps2), 64'd3);
    @(posedge clk); #1;
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    @(negedge clk);
    chk("perf_clr_grants0", 64'(pg2[0]), 64'd0);
    chk("perf_clr_stalls", 64'(ps2), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
